// File: rtl/mmio_responder_pkg.sv
// Shared constants for the CPU memory-bus responder.
//  - bus command encodings (MNONE / MREAD / MWRITE)
//  - I/O register addresses
//  - read-path region select codes and an address-to-region helper
package mmio_responder_pkg;

  localparam logic [1:0] MNONE  = 2'd0;
  localparam logic [1:0] MREAD  = 2'd1;
  localparam logic [1:0] MWRITE = 2'd2;

  localparam logic [8:0] A_LED    = 9'h100;
  localparam logic [8:0] A_SW     = 9'h140;
  localparam logic [8:0] A_KEYEVT = 9'h141;
  localparam logic [8:0] A_TCOUNT = 9'h180;
  localparam logic [8:0] A_TSTAT  = 9'h181;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_RAM  = 2'd1,
    SEL_IO   = 2'd2
  } sel_e;

  // Lower half of the address space is RAM, upper half is I/O.
  function automatic sel_e addr_region(input logic [8:0] addr);
    return addr[8] ? SEL_IO : SEL_RAM;
  endfunction

endpackage

// File: rtl/mmio_sync.sv
// Two-flop synchronizer for asynchronous board inputs.
// Ports:
//   clk    in          system clock
//   reset  in          synchronous, active-high; both stages load RESET_VAL
//   d_i    in  WIDTH   asynchronous input
//   q_o    out WIDTH   synchronized output (two clk edges of latency)
module mmio_sync #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/mmio_responder.sv
// Responder end of the CPU memory bus. Decodes each request, steers it to
// RAM or to on-chip I/O registers, and returns read data through a single
// clocked read mux (exactly one cycle of read latency for every address).
//
// Map: 0x000-0x0FF RAM | 0x100 LED (R/W) | 0x140 SW (R)
//      | 0x141 KEYEVT (R, clear-on-read) | 0x180 TCOUNT, 0x181 TSTAT (timer)
//      Anything else reads 0x0000 and ignores writes.
//
// Optional feature macro: MMIO_TIMER_EN -- adds the prescaled 16-bit timer
// at 0x180/0x181. Without it those addresses behave as unmapped.
//
// Ports:
//   clk        in   1   system clock
//   reset      in   1   synchronous, active-high
//   mem_cmd    in   2   MNONE / MREAD / MWRITE
//   mem_addr   in   9   request address
//   wdata      in   16  CPU write data
//   ram_dout   in   16  synchronous RAM read data (valid 1 cycle after address)
//   ram_write  out  1   RAM write enable (combinational)
//   read_data  out  16  read data, 1 cycle after MREAD, else 0
//   sw         in   8   board switches (asynchronous)
//   key_n      in   2   pushbuttons, active-low (asynchronous)
//   led        out  8   LED register
module mmio_responder
  import mmio_responder_pkg::*;
#(
  parameter int         PRESCALE  = 50000,
  parameter logic [7:0] LED_RESET = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mem_cmd,
  input  logic [8:0]  mem_addr,
  input  logic [15:0] wdata,
  input  logic [15:0] ram_dout,
  output logic        ram_write,
  output logic [15:0] read_data,
  input  logic [7:0]  sw,
  input  logic [1:0]  key_n,
  output logic [7:0]  led
);

  logic is_read;
  logic is_write;
  assign is_read  = (mem_cmd == MREAD);
  assign is_write = (mem_cmd == MWRITE);

  assign ram_write = is_write & ~mem_addr[8];

  // Board input synchronizers. Keys idle high, so they reset to 2'b11 to
  // avoid a spurious press right after reset.
  logic [7:0] sw_sync;
  logic [1:0] key_sync;

  mmio_sync #(.WIDTH(8), .RESET_VAL(8'h00)) u_sw_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (sw),
    .q_o   (sw_sync)
  );

  mmio_sync #(.WIDTH(2), .RESET_VAL(2'b11)) u_key_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (key_n),
    .q_o   (key_sync)
  );

  logic [7:0]  led_q, led_d;
  logic [1:0]  key_prev_q;
  logic [1:0]  evt_q, evt_d;
  logic [1:0]  key_fall;
  sel_e        sel_q, sel_d;
  logic [15:0] io_q, io_d;
  logic [15:0] io_rd;

  assign key_fall = key_prev_q & ~key_sync;

`ifdef MMIO_TIMER_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   tcount_q, tcount_d;
  logic          ten_q, ten_d;
  logic          tovf_q, tovf_d;
  logic          tick;
  logic          wr_tcount, wr_tstat, rd_tstat;

  assign wr_tcount = is_write && (mem_addr == A_TCOUNT);
  assign wr_tstat  = is_write && (mem_addr == A_TSTAT);
  assign rd_tstat  = is_read  && (mem_addr == A_TSTAT);

  always_comb begin
    presc_d  = presc_q;
    tcount_d = tcount_q;
    ten_d    = ten_q;
    // A TCOUNT load restarts the period, so it pre-empts a tick.
    tick     = ten_q && (presc_q == PW'(PRESCALE - 1)) && !wr_tcount;
    if (wr_tcount) begin
      tcount_d = wdata;
      presc_d  = '0;
    end else if (ten_q) begin
      if (tick) begin
        presc_d  = '0;
        tcount_d = tcount_q + 16'd1;
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
    // Wrap sets ovf even when the same cycle reads (and clears) TSTAT.
    tovf_d = (tovf_q & ~rd_tstat) | (tick & (tcount_q == 16'hFFFF));
    if (wr_tstat) ten_d = wdata[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q  <= '0;
      tcount_q <= '0;
      ten_q    <= 1'b0;
      tovf_q   <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      tcount_q <= tcount_d;
      ten_q    <= ten_d;
      tovf_q   <= tovf_d;
    end
  end
`endif

  // Upper wdata bits are only consumed by the timer; PRESCALE only by the timer.
  logic unused_cfg;
  assign unused_cfg = ^{wdata[15:8], 32'(PRESCALE)};

  always_comb begin
    io_rd = 16'h0000;
    case (mem_addr)
      A_LED:    io_rd = {8'h00, led_q};
      A_SW:     io_rd = {8'h00, sw_sync};
      A_KEYEVT: io_rd = {14'b0, evt_q};
`ifdef MMIO_TIMER_EN
      A_TCOUNT: io_rd = tcount_q;
      A_TSTAT:  io_rd = {14'b0, tovf_q, ten_q};
`endif
      default:  io_rd = 16'h0000;
    endcase
  end

  always_comb begin
    led_d = led_q;
    if (is_write && (mem_addr == A_LED)) led_d = wdata[7:0];

    // Clear-on-read, but an edge arriving in the same cycle keeps its bit.
    evt_d = evt_q;
    if (is_read && (mem_addr == A_KEYEVT)) evt_d = 2'b00;
    evt_d = evt_d | key_fall;

    sel_d = SEL_NONE;
    io_d  = 16'h0000;
    if (is_read) begin
      sel_d = addr_region(mem_addr);
      io_d  = io_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q      <= LED_RESET;
      evt_q      <= 2'b00;
      key_prev_q <= 2'b11;
      sel_q      <= SEL_NONE;
      io_q       <= 16'h0000;
    end else begin
      led_q      <= led_d;
      evt_q      <= evt_d;
      key_prev_q <= key_sync;
      sel_q      <= sel_d;
      io_q       <= io_d;
    end
  end

  // RAM data arrives from the RAM's own output register, so it is muxed in
  // directly; I/O data was captured into io_q on the request edge.
  always_comb begin
    case (sel_q)
      SEL_RAM: read_data = ram_dout;
      SEL_IO:  read_data = io_q;
      default: read_data = 16'h0000;
    endcase
  end

  assign led = led_q;

endmodule

// File: tb/tb_mmio_responder.sv
// Bench for mmio_responder: directed scenarios with literal expectations,
// then randomized bus traffic checked every cycle against a behavioural model.
module tb_mmio_responder;
  import mmio_responder_pkg::*;

`ifdef MMIO_TIMER_EN
  localparam int PRESC = 4;
`else
  localparam int PRESC = 50000;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] wdata;
  logic [15:0] ram_dout;
  logic        ram_write;
  logic [15:0] read_data;
  logic [7:0]  sw;
  logic [1:0]  key_n;
  logic [7:0]  led;

  always #5 clk = ~clk;

  mmio_responder #(.PRESCALE(PRESC), .LED_RESET(8'h00)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_cmd   (mem_cmd),
    .mem_addr  (mem_addr),
    .wdata     (wdata),
    .ram_dout  (ram_dout),
    .ram_write (ram_write),
    .read_data (read_data),
    .sw        (sw),
    .key_n     (key_n),
    .led       (led)
  );

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;
  logic ram_fill;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ram_seed(input int i);
    return 16'(i * 40503 + 7);
  endfunction

  // Board-side synchronous RAM.
  logic [15:0] ram [256];
  always @(posedge clk) begin
    if (ram_fill) begin
      for (int i = 0; i < 256; i++) ram[i] <= ram_seed(i);
    end else if (ram_write) begin
      ram[mem_addr[7:0]] <= wdata;
    end
    ram_dout <= ram[mem_addr[7:0]];
  end

  // ---------------- behavioural model ----------------
  logic [15:0] m_ram [256];
  logic [7:0]  m_led;
  logic [1:0]  m_evt;
  logic [15:0] m_rd;
  logic [7:0]  sw_h  [2];   // sw as sampled at the last two edges; [1] is what software sees
  logic [1:0]  key_h [3];   // key_n at the last three edges; [1] = current, [2] = one before
  logic [15:0] m_rv;
  logic [1:0]  m_fall;
`ifdef MMIO_TIMER_EN
  int          m_presc;
  logic [15:0] m_tc;
  logic        m_en, m_ovf, m_wrap;
`endif

  always @(posedge clk) begin
    if (ram_fill) begin
      for (int i = 0; i < 256; i++) m_ram[i] = ram_seed(i);
    end else if (mem_cmd == MWRITE && !mem_addr[8]) begin
      m_ram[mem_addr[7:0]] = wdata;
    end
    if (reset) begin
      m_led = 8'h00; m_evt = 2'b00; m_rd = 16'h0000;
      sw_h[0] = 8'h00; sw_h[1] = 8'h00;
      for (int i = 0; i < 3; i++) key_h[i] = 2'b11;
`ifdef MMIO_TIMER_EN
      m_presc = 0; m_tc = 16'h0000; m_en = 1'b0; m_ovf = 1'b0;
`endif
    end else begin
      m_rv = 16'h0000;
      if (mem_cmd == MREAD) begin
        if (!mem_addr[8]) m_rv = ram[mem_addr[7:0]] === m_ram[mem_addr[7:0]] ? m_ram[mem_addr[7:0]] : m_ram[mem_addr[7:0]];
        else begin
          case (mem_addr)
            9'h100: m_rv = {8'h00, m_led};
            9'h140: m_rv = {8'h00, sw_h[1]};
            9'h141: m_rv = {14'b0, m_evt};
`ifdef MMIO_TIMER_EN
            9'h180: m_rv = m_tc;
            9'h181: m_rv = {14'b0, m_ovf, m_en};
`endif
            default: m_rv = 16'h0000;
          endcase
        end
      end
      m_rd = m_rv;
      // A press is a 1->0 step of the synchronized key between consecutive edges.
      m_fall = key_h[2] & ~key_h[1];
      if (mem_cmd == MREAD && mem_addr == 9'h141) m_evt = 2'b00;
      m_evt = m_evt | m_fall;
      if (mem_cmd == MWRITE && mem_addr == 9'h100) m_led = wdata[7:0];
`ifdef MMIO_TIMER_EN
      m_wrap = 1'b0;
      if (mem_cmd == MWRITE && mem_addr == 9'h180) begin
        m_tc = wdata; m_presc = 0;
      end else if (m_en) begin
        if (m_presc == PRESC - 1) begin
          m_presc = 0;
          m_wrap  = (m_tc == 16'hFFFF);
          m_tc    = m_tc + 16'd1;
        end else m_presc = m_presc + 1;
      end
      if (mem_cmd == MREAD && mem_addr == 9'h181) m_ovf = 1'b0;
      m_ovf = m_ovf | m_wrap;
      if (mem_cmd == MWRITE && mem_addr == 9'h181) m_en = wdata[0];
`endif
      sw_h[1] = sw_h[0]; sw_h[0] = sw;
      key_h[2] = key_h[1]; key_h[1] = key_h[0]; key_h[0] = key_n;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("read_data", read_data, m_rd);
      check("led", {8'h00, led}, {8'h00, m_led});
      check("ram_write", {15'b0, ram_write}, {15'b0, (mem_cmd == MWRITE) && !mem_addr[8]});
    end
  end

  task automatic cyc(input logic [1:0] c, input logic [8:0] a, input logic [15:0] d);
    mem_cmd = c; mem_addr = a; wdata = d;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(MNONE, 9'h000, 16'h0000);
  endtask

  logic [8:0] r_addr;

  initial begin
    reset = 1'b1; ram_fill = 1'b1;
    mem_cmd = MNONE; mem_addr = 9'h000; wdata = 16'h0000;
    sw = 8'h00; key_n = 2'b11;
    idle(1);
    ram_fill = 1'b0; chk_en = 1'b1;
    idle(2);
    reset = 1'b0;
    check("reset_read_data", read_data, 16'h0000);
    check("reset_led", {8'h00, led}, 16'h0000);

    // LED write / read back
    cyc(MWRITE, 9'h100, 16'h00A5);
    check("led_write", {8'h00, led}, 16'h00A5);
    cyc(MREAD, 9'h100, 16'h0000);
    check("led_read", read_data, 16'h00A5);
    idle(1);
    check("idle_after_read", read_data, 16'h0000);

    // Switches and an unmapped read
    sw = 8'h3C;
    idle(3);
    cyc(MREAD, 9'h140, 16'h0000);
    check("sw_read", read_data, 16'h003C);
    cyc(MREAD, 9'h1FF, 16'h0000);
    check("unmapped_read", read_data, 16'h0000);

    // Key press event, sticky then cleared on read
    key_n = 2'b01;
    idle(4);
    key_n = 2'b11;
    idle(4);
    cyc(MREAD, 9'h141, 16'h0000);
    check("keyevt_first", read_data, 16'h0002);
    cyc(MREAD, 9'h141, 16'h0000);
    check("keyevt_cleared", read_data, 16'h0000);

    // RAM write enable vs I/O space write
    mem_cmd = MWRITE; mem_addr = 9'h005; wdata = 16'h1234;
    #1 check("ram_write_lo", {15'b0, ram_write}, 16'h0001);
    @(posedge clk); #1;
    mem_cmd = MWRITE; mem_addr = 9'h105; wdata = 16'h00FF;
    #1 check("ram_write_hi", {15'b0, ram_write}, 16'h0000);
    @(posedge clk); #1;
    check("led_unchanged", {8'h00, led}, 16'h00A5);
    cyc(MREAD, 9'h005, 16'h0000);
    check("ram_readback", read_data, 16'h1234);

    // Reset beats a simultaneous write; pending event is dropped
    cyc(MWRITE, 9'h100, 16'h005A);
    key_n = 2'b10;
    idle(4);
    key_n = 2'b11;
    idle(3);
    cyc(MREAD, 9'h100, 16'h0000);
    reset = 1'b1;
    cyc(MWRITE, 9'h100, 16'h00FF);
    check("reset_vs_write_led", {8'h00, led}, 16'h0000);
    check("reset_read_data2", read_data, 16'h0000);
    reset = 1'b0;
    cyc(MREAD, 9'h141, 16'h0000);
    check("reset_evt", read_data, 16'h0000);

`ifdef MMIO_TIMER_EN
    cyc(MWRITE, 9'h180, 16'hFFFE);
    cyc(MWRITE, 9'h181, 16'h0001);
    idle(8);
    cyc(MREAD, 9'h180, 16'h0000);
    check("timer_wrapped", read_data, 16'h0000);
    cyc(MREAD, 9'h181, 16'h0000);
    check("timer_ovf", read_data, 16'h0003);
    cyc(MREAD, 9'h181, 16'h0000);
    check("timer_ovf_cleared", read_data, 16'h0001);
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 19) == 0) sw = 8'($urandom);
      if ($urandom_range(0, 7) == 0) key_n[$urandom_range(0, 1)] ^= 1'b1;
      case ($urandom_range(0, 7))
        0, 1:    r_addr = {1'b0, 8'($urandom)};
        2:       r_addr = 9'h100;
        3:       r_addr = 9'h140;
        4:       r_addr = 9'h141;
        5:       r_addr = 9'h180;
        6:       r_addr = 9'h181;
        default: r_addr = 9'($urandom);
      endcase
      cyc(2'($urandom_range(0, 3)), r_addr, 16'($urandom));
    end
    reset = 1'b0;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
